uart_rx_frame_ctrl: RTL and testbench

Sequencing/buffering controller placed after the UART receiver top. It edge-detects frame completion, classifies each frame by its error flags, pushes accepted frames into a small FIFO, and presents them on a valid/ready stream to the consumer. It also owns enable/flush sequencing, overrun handling and saturating error statistics.

---
 rtl/uart_rx_pkg.sv | 18 +
 rtl/uart_rx_sync_fifo.sv | 65 ++++++
 rtl/uart_rx_frame_ctrl.sv | 132 +++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive frame controller.
// Holds the controller FSM states, the default character width and the saturating increment.
package uart_rx_pkg;

  typedef enum logic {
    ST_OFF = 1'b0,
    ST_RUN = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_SIZE = 8;

  // Counters up to 32 bits wide; the caller passes its own all-ones ceiling.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on o_rdata whenever o_empty is low.
// Flush empties the FIFO at the next edge and overrides any push or pop in the same cycle.
module uart_rx_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame sequencing/buffering controller behind the UART receiver: edge-detects frame_done,
// classifies frames, buffers them in a FIFO and keeps saturating error statistics.
// Optional macro UART_RX_PERR_DROP_EN: parity-error frames are discarded and m_perr is tied to 0.
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_SIZE  = DEFAULT_DATA_SIZE,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic                        rx_en,
  input  logic                        flush,
  input  logic                        frame_done,
  input  logic                        trans_error,
  input  logic                        data_error,
  input  logic [DATA_SIZE-1:0]        rx_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_SIZE-1:0]        m_data,
  output logic                        m_perr,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overrun,
  input  logic                        stat_clr,
  output logic [CNT_WIDTH-1:0]        trans_err_cnt,
  output logic [CNT_WIDTH-1:0]        perr_cnt,
  output logic [CNT_WIDTH-1:0]        ovr_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_frame_done_q;
  logic                 r_overrun;
  logic [CNT_WIDTH-1:0] r_cnt [3];
  logic [2:0]           w_cnt_inc;
  logic                 w_run;
  logic                 w_event;
  logic                 w_te_evt;
  logic                 w_pe_evt;
  logic                 w_store;
  logic                 w_clear;
  logic                 w_drop;
  logic                 w_full;
  logic                 w_empty;
  logic [DATA_SIZE:0]   w_wdata;
  logic [DATA_SIZE:0]   w_rdata;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) r_state <= ST_OFF;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_OFF:  if (rx_en)  w_state_next = ST_RUN;
      ST_RUN:  if (!rx_en) w_state_next = ST_OFF;
      default: w_state_next = ST_OFF;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) r_frame_done_q <= 1'b0;
    else      r_frame_done_q <= frame_done;
  end

  assign w_run    = (r_state == ST_RUN);
  assign w_event  = frame_done & ~r_frame_done_q;
  assign w_te_evt = w_run & w_event & trans_error;
  assign w_pe_evt = w_run & w_event & ~trans_error & data_error;
  // The FIFO is emptied while OFF, on the edge that enters OFF, and on flush.
  assign w_clear  = ~w_run | ~rx_en | flush;

`ifdef UART_RX_PERR_DROP_EN
  assign w_store = w_run & w_event & ~trans_error & ~data_error;
  assign w_wdata = {1'b0, rx_data};
  // Tag bit still travels through the FIFO but is forced low at the port.
  assign m_perr  = w_rdata[DATA_SIZE] & 1'b0;
`else
  assign w_store = w_run & w_event & ~trans_error;
  assign w_wdata = {data_error, rx_data};
  assign m_perr  = w_rdata[DATA_SIZE];
`endif

  assign w_drop = w_store & w_full & ~(m_ready & ~w_empty) & ~w_clear;

  uart_rx_sync_fifo #(
    .WIDTH (DATA_SIZE + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .rst     (rst),
    .i_push  (w_store & ~w_clear),
    .i_pop   (m_ready),
    .i_flush (w_clear),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  assign m_valid = ~w_empty;
  assign m_data  = w_rdata[DATA_SIZE-1:0];

  // Counter slots: 0 = transmission errors, 1 = parity errors, 2 = overrun drops.
  assign w_cnt_inc = {w_drop, w_pe_evt, w_te_evt};

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
      r_overrun <= 1'b0;
    end else if (stat_clr) begin
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
      r_overrun <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_cnt_inc[i]) r_cnt[i] <= CNT_WIDTH'(sat_inc(32'(r_cnt[i]), 32'(CNT_MAX)));
      end
      if (w_drop) r_overrun <= 1'b1;
    end
  end

  assign trans_err_cnt = r_cnt[0];
  assign perr_cnt      = r_cnt[1];
  assign ovr_cnt       = r_cnt[2];
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the frame rules.
module tb_uart_rx_frame_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 8;
  localparam int CMAX  = 255;
`ifdef UART_RX_PERR_DROP_EN
  localparam bit PDROP = 1'b1;
`else
  localparam bit PDROP = 1'b0;
`endif

  logic          sys_clk = 1'b0;
  logic          rst;
  logic          rx_en = 1'b0, flush = 1'b0, frame_done = 1'b0;
  logic          trans_error = 1'b0, data_error = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          m_valid, m_ready = 1'b0, m_perr, overrun, stat_clr = 1'b0;
  logic [DW-1:0] m_data;
  logic [2:0]    fifo_count;
  logic [CW-1:0] trans_err_cnt, perr_cnt, ovr_cnt;

  int checks = 0;
  int failures = 0;

  uart_rx_frame_ctrl #(.DATA_SIZE(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .sys_clk(sys_clk), .rst(rst), .rx_en(rx_en), .flush(flush),
    .frame_done(frame_done), .trans_error(trans_error), .data_error(data_error),
    .rx_data(rx_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_perr(m_perr), .fifo_count(fifo_count), .overrun(overrun), .stat_clr(stat_clr),
    .trans_err_cnt(trans_err_cnt), .perr_cnt(perr_cnt), .ovr_cnt(ovr_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: a queue of {tag,data} entries plus plain integer statistics.
  logic [DW:0] mq[$];
  bit  m_run = 0, m_prev = 0, m_ovr = 0;
  int  m_te = 0, m_pe = 0, m_ov = 0;

  always @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_run = 0; m_prev = 0; m_ovr = 0; m_te = 0; m_pe = 0; m_ov = 0;
    end else begin
      bit ev, pop, store;
      ev    = frame_done && !m_prev;
      pop   = m_ready && (mq.size() != 0);
      store = 0;
      if (m_run && ev) begin
        if (trans_error) begin
          if (m_te < CMAX) m_te++;
        end else begin
          if (data_error && m_pe < CMAX) m_pe++;
          store = !(data_error && PDROP);
        end
      end
      if (!m_run || !rx_en || flush) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (store) begin
          if (mq.size() < DEPTH) mq.push_back({(data_error && !PDROP), rx_data});
          else begin
            if (m_ov < CMAX) m_ov++;
            m_ovr = 1;
          end
        end
      end
      if (stat_clr) begin m_te = 0; m_pe = 0; m_ov = 0; m_ovr = 0; end
      m_run  = rx_en;
      m_prev = frame_done;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic te, input logic de);
    frame_done = 1'b1; rx_data = d; trans_error = te; data_error = de;
    @(negedge sys_clk);
    frame_done = 1'b0; trans_error = 1'b0; data_error = 1'b0;
  endtask

  task automatic pulse_stat_clr();
    stat_clr = 1'b1;
    @(negedge sys_clk);
    stat_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++;
    if ({m_valid, m_data, m_perr, fifo_count, overrun} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%0b data=%h perr=%0b cnt=%0d ovr=%0b required all 0",
               m_valid, m_data, m_perr, fifo_count, overrun);
    end
    checks++;
    if ({trans_err_cnt, perr_cnt, ovr_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_counters got te=%0d pe=%0d ov=%0d required 0", trans_err_cnt, perr_cnt, ovr_cnt);
    end
    @(negedge sys_clk);
    rst = 1'b1;
    rx_en = 1'b1;
    tick(2);
  endtask

  task automatic test_clean_frames();
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [DW-1:0] d;
      d = DW'(8'h41 + i);
      checks++;
      if (m_valid !== 1'b0) begin
        failures++; $display("FAIL clean_valid_before got=%0b required=0", m_valid);
      end
      send_frame(d, 1'b0, 1'b0);
      checks++;
      if (m_valid !== 1'b1 || m_data !== d || m_perr !== 1'b0) begin
        failures++;
        $display("FAIL clean_head got valid=%0b data=%h perr=%0b required valid=1 data=%h perr=0",
                 m_valid, m_data, m_perr, d);
      end
      $display("clean frame %0d delivered data=%h", i, m_data);
      tick(1);
      checks++;
      if (m_valid !== 1'b0) begin
        failures++; $display("FAIL clean_valid_after_pop got=%0b required=0", m_valid);
      end
    end
    checks++;
    if (fifo_count !== 3'd0) begin
      failures++; $display("FAIL clean_count got=%0d required=0", fifo_count);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_errors();
    pulse_stat_clr();
    send_frame(8'h99, 1'b1, 1'b0); tick(1);
    send_frame(8'h77, 1'b1, 1'b1); tick(1);
    send_frame(8'h55, 1'b0, 1'b1); tick(1);
    checks++;
    if (trans_err_cnt !== 8'd2 || perr_cnt !== 8'd1) begin
      failures++;
      $display("FAIL err_counts got te=%0d pe=%0d required te=2 pe=1", trans_err_cnt, perr_cnt);
    end
`ifdef UART_RX_PERR_DROP_EN
    checks++;
    if (fifo_count !== 3'd0 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL err_drop got cnt=%0d valid=%0b required cnt=0 valid=0", fifo_count, m_valid);
    end
`else
    checks++;
    if (fifo_count !== 3'd1 || m_valid !== 1'b1 || m_data !== 8'h55 || m_perr !== 1'b1) begin
      failures++;
      $display("FAIL err_entry got cnt=%0d valid=%0b data=%h perr=%0b required cnt=1 valid=1 data=55 perr=1",
               fifo_count, m_valid, m_data, m_perr);
    end
`endif
    $display("error frames: te=%0d pe=%0d count=%0d", trans_err_cnt, perr_cnt, fifo_count);
    m_ready = 1'b1; tick(1); m_ready = 1'b0;
  endtask

  task automatic test_overrun();
    pulse_stat_clr();
    for (int i = 0; i < 6; i++) begin
      send_frame(DW'(8'h10 + i), 1'b0, 1'b0);
      tick(1);
    end
    checks++;
    if (fifo_count !== 3'd4 || ovr_cnt !== 8'd2 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_state got cnt=%0d ovr_cnt=%0d overrun=%0b required 4 2 1", fifo_count, ovr_cnt, overrun);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== DW'(8'h10 + i)) begin
        failures++;
        $display("FAIL ovr_drain%0d got valid=%0b data=%h required data=%h", i, m_valid, m_data, DW'(8'h10 + i));
      end
      $display("overrun drain %0d data=%h", i, m_data);
      tick(1);
    end
    m_ready = 1'b0;
    checks++;
    if (fifo_count !== 3'd0 || m_valid !== 1'b0) begin
      failures++; $display("FAIL ovr_empty got cnt=%0d valid=%0b required 0 0", fifo_count, m_valid);
    end
    pulse_stat_clr();
    checks++;
    if (overrun !== 1'b0 || ovr_cnt !== 8'd0) begin
      failures++; $display("FAIL stat_clr got overrun=%0b ovr_cnt=%0d required 0 0", overrun, ovr_cnt);
    end
  endtask

  task automatic test_full_pop_push();
    for (int i = 0; i < 4; i++) begin
      send_frame(DW'(8'h20 + i), 1'b0, 1'b0);
      tick(1);
    end
    m_ready = 1'b1;
    send_frame(8'h24, 1'b0, 1'b0);
    m_ready = 1'b0;
    checks++;
    if (fifo_count !== 3'd4 || overrun !== 1'b0 || ovr_cnt !== 8'd0 || m_data !== 8'h21) begin
      failures++;
      $display("FAIL full_pop_push got cnt=%0d overrun=%0b ovr_cnt=%0d head=%h required 4 0 0 21",
               fifo_count, overrun, ovr_cnt, m_data);
    end
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (m_data !== DW'(8'h20 + i)) begin
        failures++; $display("FAIL fpp_order%0d got=%h required=%h", i, m_data, DW'(8'h20 + i));
      end
      tick(1);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_level_hold();
    frame_done = 1'b1; rx_data = 8'h66;
    tick(10);
    frame_done = 1'b0;
    tick(1);
    checks++;
    if (fifo_count !== 3'd1 || m_data !== 8'h66) begin
      failures++; $display("FAIL level_hold got cnt=%0d data=%h required 1 66", fifo_count, m_data);
    end
    m_ready = 1'b1; tick(1); m_ready = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      send_frame(DW'(8'h30 + i), 1'b0, 1'b0);
      tick(1);
    end
    flush = 1'b1; frame_done = 1'b1; rx_data = 8'h33;
    tick(1);
    flush = 1'b0; frame_done = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || fifo_count !== 3'd0 || ovr_cnt !== 8'd0) begin
      failures++;
      $display("FAIL flush got valid=%0b cnt=%0d ovr_cnt=%0d required 0 0 0", m_valid, fifo_count, ovr_cnt);
    end
    tick(1);
    checks++;
    if (m_valid !== 1'b0) begin
      failures++; $display("FAIL flush_push_discard got valid=%0b required=0", m_valid);
    end
  endtask

  task automatic test_disable();
    int te_before;
    send_frame(8'h40, 1'b0, 1'b0); tick(1);
    send_frame(8'h41, 1'b0, 1'b0);
    rx_en = 1'b0;
    tick(1);
    checks++;
    if (fifo_count !== 3'd0 || m_valid !== 1'b0) begin
      failures++; $display("FAIL disable_empty got cnt=%0d valid=%0b required 0 0", fifo_count, m_valid);
    end
    te_before = int'(trans_err_cnt);
    send_frame(8'h42, 1'b1, 1'b0); tick(1);
    send_frame(8'h43, 1'b0, 1'b0); tick(1);
    checks++;
    if (fifo_count !== 3'd0 || int'(trans_err_cnt) != te_before) begin
      failures++;
      $display("FAIL disable_ignore got cnt=%0d te=%0d required cnt=0 te=%0d", fifo_count, trans_err_cnt, te_before);
    end
    rx_en = 1'b1;
    tick(1);
    send_frame(8'h44, 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h44) begin
      failures++; $display("FAIL reenable got valid=%0b data=%h required 1 44", m_valid, m_data);
    end
    m_ready = 1'b1; tick(1); m_ready = 1'b0;
  endtask

  task automatic test_saturation();
    pulse_stat_clr();
    for (int i = 0; i < 260; i++) begin
      send_frame(DW'(i), 1'b1, 1'b0);
      tick(1);
    end
    checks++;
    if (int'(trans_err_cnt) != CMAX || int'(trans_err_cnt) != m_te) begin
      failures++; $display("FAIL saturate got=%0d required=%0d", trans_err_cnt, CMAX);
    end
    $display("saturation: trans_err_cnt=%0d", trans_err_cnt);
    pulse_stat_clr();
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      checks++;
      if (m_valid !== (mq.size() != 0)) begin
        failures++; $display("FAIL rnd_valid cyc=%0d got=%0b required=%0b", c, m_valid, mq.size() != 0);
      end
      checks++;
      if (int'(fifo_count) != mq.size()) begin
        failures++; $display("FAIL rnd_count cyc=%0d got=%0d required=%0d", c, fifo_count, mq.size());
      end
      if (mq.size() != 0) begin
        checks++;
        if ({m_perr, m_data} !== mq[0]) begin
          failures++; $display("FAIL rnd_head cyc=%0d got=%h required=%h", c, {m_perr, m_data}, mq[0]);
        end
      end
      checks++;
      if (overrun !== m_ovr || int'(trans_err_cnt) != m_te || int'(perr_cnt) != m_pe || int'(ovr_cnt) != m_ov) begin
        failures++;
        $display("FAIL rnd_stats cyc=%0d got ovr=%0b te=%0d pe=%0d ov=%0d required %0b %0d %0d %0d",
                 c, overrun, trans_err_cnt, perr_cnt, ovr_cnt, m_ovr, m_te, m_pe, m_ov);
      end
      frame_done  = ($urandom_range(0, 99) < 45);
      rx_data     = DW'($urandom);
      trans_error = ($urandom_range(0, 7) == 0);
      data_error  = ($urandom_range(0, 4) == 0);
      m_ready     = ($urandom_range(0, 2) == 0);
      flush       = ($urandom_range(0, 59) == 0);
      stat_clr    = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 79) == 0) rx_en = ~rx_en;
      @(negedge sys_clk);
    end
    frame_done = 1'b0; trans_error = 1'b0; data_error = 1'b0;
    flush = 1'b0; stat_clr = 1'b0; m_ready = 1'b0; rx_en = 1'b1;
    tick(2);
  endtask

  task automatic test_async_reset();
    flush = 1'b1; tick(1); flush = 1'b0;
    send_frame(8'h50, 1'b1, 1'b0); tick(1);
    send_frame(8'h51, 1'b0, 1'b1); tick(1);
    send_frame(8'h52, 1'b0, 1'b0); tick(1);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({m_valid, m_data, m_perr, fifo_count, overrun} !== '0 || {trans_err_cnt, perr_cnt, ovr_cnt} !== '0) begin
      failures++;
      $display("FAIL async_reset got valid=%0b data=%h perr=%0b cnt=%0d ovr=%0b te=%0d pe=%0d ov=%0d required all 0",
               m_valid, m_data, m_perr, fifo_count, overrun, trans_err_cnt, perr_cnt, ovr_cnt);
    end
    @(negedge sys_clk);
    rst = 1'b1;
    tick(2);
    send_frame(8'hA5, 1'b0, 1'b0);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5 || fifo_count !== 3'd1) begin
      failures++;
      $display("FAIL post_reset_frame got valid=%0b data=%h cnt=%0d required 1 a5 1", m_valid, m_data, fifo_count);
    end
    $display("post-reset frame data=%h", m_data);
    m_ready = 1'b1; tick(1); m_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_frames();
    test_errors();
    test_overrun();
    test_full_pop_push();
    test_level_hold();
    test_flush();
    test_disable();
    test_saturation();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
